btn_press_decoder: RTL

BTN_PRESS_DECODER -- requirements
Module: btn_press_decoder

---
 rtl/btn_press_decoder.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/btn_press_decoder.sv
// Two-button press classifier: debounce, short/long press FSM and event hold stretch per button.
// Define BTN_SYNC_EN to put a 2-flop synchronizer in front of each debouncer (+2 cycles latency).
module btn_press_decoder #(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
    parameter int unsigned LONG_CYCLES     = 100_000_000,
    parameter int unsigned HOLD_CYCLES     = 100_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn0,
    input  logic btn1,
    output logic b0short,
    output logic b0long,
    output logic b1short,
    output logic b1long
);

    localparam int unsigned DW = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam int unsigned PW = $clog2(LONG_CYCLES) + 1;
    localparam int unsigned HW = $clog2(HOLD_CYCLES) + 1;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PRESSED  = 2'd1,
        LONGHELD = 2'd2
    } press_state_t;

    logic [1:0] raw;
    logic [1:0] short_q;
    logic [1:0] long_q;

    assign raw = {btn1, btn0};

    for (genvar ch = 0; ch < 2; ch++) begin : g_ch
        logic sample;

`ifdef BTN_SYNC_EN
        logic [1:0] sync_q;

        always_ff @(posedge clk) begin
            if (rst) sync_q <= '0;
            else     sync_q <= {sync_q[0], raw[ch]};
        end

        assign sample = sync_q[1];
`else
        assign sample = raw[ch];
`endif

        // Debouncer: level follows the sample only after an unbroken run of differing samples
        logic          level;
        logic [DW-1:0] deb_cnt;

        always_ff @(posedge clk) begin
            if (rst) begin
                level   <= 1'b0;
                deb_cnt <= '0;
            end else if (sample == level) begin
                deb_cnt <= '0;
            end else if (deb_cnt == DW'(DEBOUNCE_CYCLES - 1)) begin
                level   <= sample;
                deb_cnt <= '0;
            end else begin
                deb_cnt <= deb_cnt + DW'(1);
            end
        end

        press_state_t  state;
        press_state_t  state_nxt;
        logic [PW-1:0] press_cnt;
        logic [PW-1:0] press_cnt_nxt;
        logic          short_ev_c;
        logic          long_ev_c;

        always_ff @(posedge clk) begin
            if (rst) begin
                state     <= IDLE;
                press_cnt <= '0;
            end else begin
                state     <= state_nxt;
                press_cnt <= press_cnt_nxt;
            end
        end

        // Long event fires on the edge where the press count reaches LONG_CYCLES
        always_comb begin
            state_nxt     = state;
            press_cnt_nxt = press_cnt;
            short_ev_c    = 1'b0;
            long_ev_c     = 1'b0;
            case (state)
                IDLE: begin
                    if (level) begin
                        state_nxt     = PRESSED;
                        press_cnt_nxt = PW'(1);
                    end
                end
                PRESSED: begin
                    if (!level) begin
                        state_nxt     = IDLE;
                        press_cnt_nxt = '0;
                        short_ev_c    = 1'b1;
                    end else if (press_cnt >= PW'(LONG_CYCLES - 1)) begin
                        state_nxt     = LONGHELD;
                        press_cnt_nxt = PW'(LONG_CYCLES);
                        long_ev_c     = 1'b1;
                    end else begin
                        press_cnt_nxt = press_cnt + PW'(1);
                    end
                end
                LONGHELD: begin
                    if (!level) begin
                        state_nxt     = IDLE;
                        press_cnt_nxt = '0;
                    end
                end
                default: begin
                    state_nxt     = IDLE;
                    press_cnt_nxt = '0;
                end
            endcase
        end

        // Hold stretchers: a new event always restarts the count, taking priority over expiry
        logic          s_q;
        logic          l_q;
        logic [HW-1:0] s_cnt;
        logic [HW-1:0] l_cnt;

        always_ff @(posedge clk) begin
            if (rst) begin
                s_q   <= 1'b0;
                s_cnt <= '0;
                l_q   <= 1'b0;
                l_cnt <= '0;
            end else begin
                if (short_ev_c) begin
                    s_q   <= 1'b1;
                    s_cnt <= '0;
                end else if (s_q) begin
                    if (s_cnt == HW'(HOLD_CYCLES - 1)) begin
                        s_q   <= 1'b0;
                        s_cnt <= '0;
                    end else begin
                        s_cnt <= s_cnt + HW'(1);
                    end
                end
                if (long_ev_c) begin
                    l_q   <= 1'b1;
                    l_cnt <= '0;
                end else if (l_q) begin
                    if (l_cnt == HW'(HOLD_CYCLES - 1)) begin
                        l_q   <= 1'b0;
                        l_cnt <= '0;
                    end else begin
                        l_cnt <= l_cnt + HW'(1);
                    end
                end
            end
        end

        assign short_q[ch] = s_q;
        assign long_q[ch]  = l_q;
    end

    assign b0short = short_q[0];
    assign b0long  = long_q[0];
    assign b1short = short_q[1];
    assign b1long  = long_q[1];

endmodule
